// File: rtl/i2c_apb_arbiter.sv
// i2c_apb_arbiter: round-robin arbiter sequencing NUM_REQ requesters onto one I2C command port.
module i2c_apb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096,
  parameter int GAP_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_wr,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_grant,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_error,
  output logic                 i2c_ce,
  output logic                 i2c_wren,
  output logic                 i2c_rden,
  output logic [7:0]           i2c_addr,
  output logic [7:0]           i2c_wdata,
  input  logic                 i2c_ready,
  input  logic                 i2c_error,
  input  logic [7:0]           i2c_rdata
);
  localparam int RW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2((TIMEOUT > GAP_CYC ? TIMEOUT : GAP_CYC) + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rr, win, pick;
  logic [NUM_REQ-1:0] win_oh;
  logic own, any, tmo, gap_end, cmd_wr;
  logic [7:0] cmd_addr, cmd_wdata;
  always_comb begin
    pick = '0;
    any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[(int'(rr) + i) % NUM_REQ]) begin
        pick = RW'((int'(rr) + i) % NUM_REQ);
        any = 1'b1;
      end
  end
  assign tmo     = cnt == CW'(TIMEOUT - 1);
  assign gap_end = cnt == CW'(GAP_CYC - 1);
  assign win_oh  = NUM_REQ'(1) << win;
  // A winner is latched in IDLE first (grant only); the command goes out the cycle after.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = own ? ISSUE : IDLE;
      ISSUE:   state_n = (i2c_ready || tmo) ? RESP : ISSUE;
      RESP:    state_n = GAP;
      default: state_n = gap_end ? IDLE : GAP;
    endcase
  end
  assign i2c_ce    = state == ISSUE;
  assign i2c_wren  = i2c_ce & cmd_wr;
  assign i2c_rden  = i2c_ce & ~cmd_wr;
  assign i2c_addr  = i2c_ce ? cmd_addr : '0;
  assign i2c_wdata = i2c_ce ? cmd_wdata : '0;
  assign req_grant = own ? win_oh : '0;
  assign req_done  = (own && state == RESP) ? win_oh : '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      rr        <= '0;
      win       <= '0;
      own       <= 1'b0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      cnt <= ((state == ISSUE || state == GAP) && state_n == state) ? cnt + 1'b1 : '0;
      if (state == IDLE && !own && any) begin
        own       <= 1'b1;
        win       <= pick;
        cmd_wr    <= req_wr[pick];
        cmd_addr  <= req_addr[pick*8 +: 8];
        cmd_wdata <= req_wdata[pick*8 +: 8];
      end
      if (state == ISSUE && (i2c_ready || tmo)) begin
        rsp_rdata <= i2c_ready ? i2c_rdata : '0;
        rsp_error <= i2c_ready ? i2c_error : 1'b1;
      end
      if (state == RESP) begin
        own <= 1'b0;
        rr  <= (win == RW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// tb_i2c_apb_arbiter: directed scenarios against a small I2C slave model (device id 1 only).
module tb_i2c_apb_arbiter;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;
  localparam int GAP_CYC = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] req_valid = '0, req_wr = '0, req_grant, req_done;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [7:0] rsp_rdata, i2c_addr, i2c_wdata, i2c_rdata = '0;
  logic rsp_error, i2c_ce, i2c_wren, i2c_rden, i2c_ready = 1'b0, i2c_error = 1'b0;
  logic [7:0] mem [64];
  bit mute = 1'b0;
  int lat = 0, tests = 0, fails = 0;

  i2c_apb_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_grant(req_grant), .req_done(req_done), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .i2c_ce(i2c_ce), .i2c_wren(i2c_wren), .i2c_rden(i2c_rden),
    .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_ready(i2c_ready), .i2c_error(i2c_error),
    .i2c_rdata(i2c_rdata));

  always #5 clk = ~clk;

  // Slave answers with a one-cycle ready on the third ce-high cycle unless muted.
  always @(negedge clk) begin
    if (!i2c_ce) begin
      lat = 0;
      i2c_ready = 1'b0;
    end else if (!mute && !i2c_ready) begin
      lat++;
      if (lat == 3) begin
        i2c_ready = 1'b1;
        i2c_error = i2c_addr[7:6] != 2'd1;
        i2c_rdata = i2c_wren ? 8'h00 : mem[i2c_addr[5:0]];
        if (i2c_wren && i2c_addr[7:6] == 2'd1) mem[i2c_addr[5:0]] = i2c_wdata;
      end
    end else i2c_ready = 1'b0;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int lim, output logic [3:0] d, output int ce_cyc,
                           output logic [3:0] g, output bit rd, output bit wr);
    d = '0; ce_cyc = 0; g = '0; rd = 0; wr = 0;
    for (int i = 0; i < lim && d == 0; i++) begin
      tick();
      if (i2c_ce) begin
        ce_cyc++;
        g = req_grant;
        rd |= i2c_rden;
        wr |= i2c_wren;
      end
      d = req_done;
    end
  endtask

  task automatic test_reset();
    tick();
    tests++;
    if ({req_grant, req_done, rsp_rdata, rsp_error, i2c_ce, i2c_wren, i2c_rden, i2c_addr, i2c_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got grant=%b done=%b rdata=%h err=%b ce=%b addr=%h, expected all 0",
               req_grant, req_done, rsp_rdata, rsp_error, i2c_ce, i2c_addr);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    bit seen_ready = 0;
    req_wr = 4'b0001; req_addr[7:0] = 8'h41; req_wdata[7:0] = 8'h5F; req_valid = 4'b0001;
    tick();
    tests++;
    if (req_grant !== 4'b0001 || i2c_ce !== 1'b0) begin
      fails++;
      $display("FAIL sw_grant_cycle: grant=%b ce=%b, expected grant=0001 ce=0", req_grant, i2c_ce);
    end
    tick();
    tests++;
    if ({i2c_ce, i2c_wren, i2c_rden, i2c_addr, i2c_wdata} !== {3'b110, 8'h41, 8'h5F}) begin
      fails++;
      $display("FAIL sw_issue: ce=%b wren=%b rden=%b addr=%h wdata=%h, expected 1 1 0 41 5F",
               i2c_ce, i2c_wren, i2c_rden, i2c_addr, i2c_wdata);
    end
    for (int i = 0; i < 20 && !seen_ready; i++) begin
      tests++;
      if ({i2c_ce, i2c_addr, i2c_wdata} !== {1'b1, 8'h41, 8'h5F}) begin
        fails++;
        $display("FAIL sw_stable: ce=%b addr=%h wdata=%h, expected 1 41 5F", i2c_ce, i2c_addr, i2c_wdata);
      end
      seen_ready = i2c_ready;
      if (!seen_ready) tick();
    end
    tick();
    req_valid = '0;
    tests++;
    if (req_done !== 4'b0001 || rsp_error !== 1'b0 || i2c_ce !== 1'b0) begin
      fails++;
      $display("FAIL sw_done: done=%b err=%b ce=%b, expected 0001 0 0", req_done, rsp_error, i2c_ce);
    end
    tick();
    tests++;
    if (req_done !== 4'b0000) begin
      fails++;
      $display("FAIL sw_done_pulse: done=%b, expected 0000", req_done);
    end
    tests++;
    if (mem[1] !== 8'h5F) begin
      fails++;
      $display("FAIL sw_memory: mem[1]=%h, expected 5F", mem[1]);
    end
  endtask

  task automatic test_read_back();
    logic [3:0] d, g; int c; bit rd, wr;
    req_wr = 4'b0000; req_addr[7:0] = 8'h41; req_valid = 4'b0001;
    wait_done(200, d, c, g, rd, wr);
    req_valid = '0;
    tests++;
    if (d !== 4'b0001 || !rd || wr || rsp_rdata !== 8'h5F || rsp_error !== 1'b0) begin
      fails++;
      $display("FAIL read_back: done=%b rd=%b wr=%b rdata=%h err=%b, expected 0001 1 0 5F 0",
               d, rd, wr, rsp_rdata, rsp_error);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] d, g; int c, n; bit rd, wr;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    reset = 1'b0; tick(); reset = 1'b1;
    req_wr = 4'b1111; req_addr = 32'h4B4A4948; req_wdata = 32'hD3D2D1D0; req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(200, d, c, g, rd, wr);
      tests++;
      if (d !== 4'(1 << exp_order[k]) || g !== d) begin
        fails++;
        $display("FAIL rr_order[%0d]: done=%b grant=%b, expected %b", k, d, g, 4'(1 << exp_order[k]));
      end
      if (k < 4) begin
        n = 0;
        for (int i = 0; i < 100 && !i2c_ce; i++) begin
          n++;
          tick();
        end
        tests++;
        if (n < GAP_CYC) begin
          fails++;
          $display("FAIL rr_gap[%0d]: ce low for %0d cycles, expected >= %0d", k, n, GAP_CYC);
        end
      end
    end
    req_valid = '0;
    tests++;
    if (mem[8'h0A] !== 8'hD2) begin
      fails++;
      $display("FAIL rr_memory: mem[0A]=%h, expected D2", mem[8'h0A]);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] d, g; int c; bit rd, wr;
    mute = 1'b1;
    req_wr = 4'b0000; req_addr[23:16] = 8'h42; req_valid = 4'b0100;
    wait_done(TIMEOUT + 60, d, c, g, rd, wr);
    req_valid = '0;
    tests++;
    if (d !== 4'b0100 || c != TIMEOUT || rsp_error !== 1'b1 || rsp_rdata !== 8'h00 || i2c_ce !== 1'b0) begin
      fails++;
      $display("FAIL timeout: done=%b ce_cycles=%0d err=%b rdata=%h ce=%b, expected 0100 %0d 1 00 0",
               d, c, rsp_error, rsp_rdata, i2c_ce, TIMEOUT);
    end
    mute = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] d, g; int c; bit rd, wr;
    req_wr = 4'b1000; req_addr[15:8] = 8'h41; req_addr[31:24] = 8'h4C; req_wdata[31:24] = 8'h77;
    req_valid = 4'b0010;
    for (int i = 0; i < 50 && !i2c_ce; i++) tick();
    reset = 1'b0;
    #1;
    tests++;
    if ({req_grant, req_done, i2c_ce, i2c_wren, i2c_rden, i2c_addr} !== '0) begin
      fails++;
      $display("FAIL reset_mid: grant=%b done=%b ce=%b wren=%b rden=%b addr=%h, expected all 0",
               req_grant, req_done, i2c_ce, i2c_wren, i2c_rden, i2c_addr);
    end
    req_valid = 4'b1010;
    tick();
    tests++;
    if (req_done !== 4'b0000) begin
      fails++;
      $display("FAIL reset_no_done: done=%b, expected 0000", req_done);
    end
    reset = 1'b1;
    wait_done(200, d, c, g, rd, wr);
    req_valid = 4'b1000;
    tests++;
    if (d !== 4'b0010 || rsp_rdata !== 8'h5F) begin
      fails++;
      $display("FAIL reset_rr_first: done=%b rdata=%h, expected 0010 5F", d, rsp_rdata);
    end
    wait_done(200, d, c, g, rd, wr);
    req_valid = '0;
    tests++;
    if (d !== 4'b1000 || !wr || mem[8'h0C] !== 8'h77) begin
      fails++;
      $display("FAIL reset_rr_second: done=%b wr=%b mem[0C]=%h, expected 1000 1 77", d, wr, mem[8'h0C]);
    end
  endtask

  task automatic test_error_recover();
    logic [3:0] d, g; int c; bit rd, wr;
    req_wr = 4'b0000; req_addr[7:0] = 8'hC1; req_valid = 4'b0001;
    wait_done(200, d, c, g, rd, wr);
    req_addr[7:0] = 8'h41;
    tests++;
    if (d !== 4'b0001 || rsp_error !== 1'b1) begin
      fails++;
      $display("FAIL err_bad_dev: done=%b err=%b, expected 0001 1", d, rsp_error);
    end
    wait_done(200, d, c, g, rd, wr);
    req_valid = '0;
    tests++;
    if (d !== 4'b0001 || rsp_error !== 1'b0 || rsp_rdata !== 8'h5F) begin
      fails++;
      $display("FAIL err_recover: done=%b err=%b rdata=%h, expected 0001 0 5F", d, rsp_error, rsp_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    test_reset();
    test_single_write();
    test_read_back();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_error_recover();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
